multi_channel_dma_ctrl: RTL
===========================

// Module: multi_channel_dma_ctrl
// PURPOSE
//  Next-generation DMA controller: NUM_CH independent channels, each with its own descriptor, status and IRQ.
//  Round-robin arbitration onto one shared read-engine and one write-engine command/status pair.
//  Adds per-channel abort and tags every command with its channel ID.
//  Sits between the per-channel register file and the read/write transaction splitters.
// PARAMETERS
//  NUM_CH   4   number of channels (2..16)
//  ADDR_W   32  address width
//  LEN_W    32  byte-count width
//  ID_W     $clog2(NUM_CH)  channel-ID width (derived; not overridden)
// PORTS
//  ACLK          in   1             clock; all logic on posedge
//  ARESET        in   1             reset, synchronous, active-high
//  ch_go         in   NUM_CH        per-channel start pulse
//  ch_abort      in   NUM_CH        per-channel abort pulse
//  ch_src_addr   in   NUM_CH*ADDR_W source addresses, channel i at [i*ADDR_W +: ADDR_W]
//  ch_dst_addr   in   NUM_CH*ADDR_W destination addresses, same packing
//  ch_length     in   NUM_CH*LEN_W  byte counts, same packing
//  ch_irq_en     in   NUM_CH        per-channel interrupt enable
//  ch_irq_clr    in   NUM_CH        per-channel IRQ-status clear pulse
//  ch_busy       out  NUM_CH        channel queued or in flight
//  ch_stat       out  NUM_CH*2      last completion code: 00 ok, 01 engine err, 10 zero length, 11 aborted
//  ch_irq_status out  NUM_CH        sticky completion flag
//  irq           out  1             |(ch_irq_status & ch_irq_en)
//  rd_cmd_valid/ready  out/in  1    read command handshake
//  rd_cmd_addr, rd_cmd_len  out  ADDR_W, LEN_W  read command payload
//  rd_cmd_id     out  ID_W          owning channel
//  rd_stat_valid/ready  in/out  1   read status handshake
//  rd_stat_code  in   2             read status code
//  wr_cmd_*, wr_stat_*  same as rd_*; wr_cmd_addr carries the destination address
// BEHAVIOUR
//  Reset: all outputs 0; pending, aborted and ch_stat registers 0; rr pointer = channel 0; FSM IDLE.
//  Accepting go (cycle T): ch_go[i] with channel not busy and length!=0 sets pending[i]; ch_busy[i]=1 at T+1.
//  Ignored go: a ch_go on a busy channel has no effect.
//  Zero length: ch_stat[i]=10 and ch_irq_status[i]=1 at T+1; ch_busy never asserts.
//  Go + abort same cycle, same channel: abort wins; no state change.
//  Abort of a pending (not granted) channel: clear pending; ch_stat=11, irq_status=1, busy=0, all next cycle.
//  Abort of the granted channel: set aborted flag; the transfer runs to completion (no valid withdrawal).
//  FSM states IDLE, POST, STAT:
//   IDLE: if any pending, grant the first pending channel searching from rr_ptr+1 (wrap mod NUM_CH).
//    Load rd/wr cmd payloads and id; assert both cmd_valid; clear pending[g]; go to POST. Otherwise stay in IDLE.
//   POST: each cmd_valid stays high with a stable payload until its ready; it drops the cycle after the handshake.
//    Go to STAT once both handshakes have completed (they may occur in different cycles or the same cycle).
//   STAT: rd_stat_ready = wr_stat_ready = 1 until that side has been captured once; then 0.
//    When both are captured, next cycle: write ch_stat[g], set ch_irq_status[g], clear ch_busy[g].
//    In the same cycle: rr_ptr=g, return to IDLE.
//  Completion code priority: aborted -> 11; else read code !=0 -> read code; else write code.
//  Grant latency: IDLE to cmd_valid is 1 cycle; back-to-back channels have 1 idle cycle between completion and the next valid.
//  One channel in flight at a time; others stay pending. Round-robin prevents starvation.
//  IRQ: ch_irq_clr clears the flag; a set in the same cycle wins over a clear. irq is combinational from registers.
//  Descriptor inputs are sampled only at grant; later changes do not affect the active transfer.
//  Mid-operation reset: returns to the reset state in one cycle; cmd_valid drops immediately; in-flight status is discarded.
// TESTING
//  1 Ch0 go, src=0x1000 dst=0x2000 len=64, both readies high -> rd/wr cmd with id0 at T+2.
//    Both stats 00 -> ch_stat0=00, irq_status0=1, and irq=1 if enabled.
//  2 Go on ch0..3 in one cycle, rr_ptr=0 -> grants in order 1,2,3,0, each completing before the next valid.
//  3 Ch2 len=0 -> ch_stat2=10, irq_status2=1 next cycle; no cmd_valid ever asserted.
//  4 Ch1 pending behind active ch0, abort ch1 -> ch_stat1=11 next cycle.
//    Ch0 unaffected; ch1 never appears on cmd_id.
//  5 Abort of the granted ch3 during POST with wr_ready held low 5 cycles -> wr_cmd_valid stays high.
//    Transfer completes; ch_stat3=11.
//  6 rd_stat=01, wr_stat=00 -> ch_stat=01. Then irq_clr in the same cycle as a new completion -> irq_status stays 1.

Source files
------------

// File: rtl/multi_channel_dma_ctrl.sv
// Multi-channel DMA controller: per-channel descriptor/status/IRQ state,
// round-robin grant onto one shared read engine and one shared write engine.
// Only one channel is in flight at a time; each command carries its channel ID.

// Per-channel bookkeeping: pending/busy/aborted flags, last completion code, IRQ flag.
module dma_ch_state (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       go_i,
  input  logic       abort_i,
  input  logic       len_zero_i,
  input  logic       grant_i,
  input  logic       done_i,
  input  logic [1:0] code_i,
  input  logic       irq_clr_i,
  output logic       pending_o,
  output logic       busy_o,
  output logic [1:0] stat_o,
  output logic       irq_status_o
);
  logic       pending_q, pending_d;
  logic       busy_q, busy_d;
  logic       aborted_q, aborted_d;
  logic [1:0] stat_q, stat_d;
  logic       irq_q, irq_d;

  // Next-state: idle channels accept go, pending channels may be aborted outright,
  // the granted channel only records an abort and finishes its transfer.
  always_comb begin
    pending_d = pending_q;
    busy_d    = busy_q;
    aborted_d = aborted_q;
    stat_d    = stat_q;
    irq_d     = irq_q & ~irq_clr_i;  // any set below overrides the clear
    if (!busy_q) begin
      if (go_i && !abort_i) begin
        if (len_zero_i) begin
          stat_d = 2'b10;
          irq_d  = 1'b1;
        end else begin
          pending_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
    end else if (pending_q && !grant_i) begin
      if (abort_i) begin
        pending_d = 1'b0;
        busy_d    = 1'b0;
        stat_d    = 2'b11;
        irq_d     = 1'b1;
      end
    end else begin
      // Granted this cycle or in flight
      if (grant_i) pending_d = 1'b0;
      if (abort_i) aborted_d = 1'b1;
      if (done_i) begin
        busy_d    = 1'b0;
        aborted_d = 1'b0;
        stat_d    = (aborted_q || abort_i) ? 2'b11 : code_i;
        irq_d     = 1'b1;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
      stat_q    <= 2'b00;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      busy_q    <= busy_d;
      aborted_q <= aborted_d;
      stat_q    <= stat_d;
      irq_q     <= irq_d;
    end
  end

  assign pending_o    = pending_q;
  assign busy_o       = busy_q;
  assign stat_o       = stat_q;
  assign irq_status_o = irq_q;
endmodule

module multi_channel_dma_ctrl #(
  parameter  int NUM_CH = 4,
  parameter  int ADDR_W = 32,
  parameter  int LEN_W  = 32,
  localparam int ID_W   = $clog2(NUM_CH)
) (
  input  logic                     aclk_i,
  input  logic                     areset_i,
  input  logic [NUM_CH-1:0]        ch_go_i,
  input  logic [NUM_CH-1:0]        ch_abort_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_src_addr_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_dst_addr_i,
  input  logic [NUM_CH*LEN_W-1:0]  ch_length_i,
  input  logic [NUM_CH-1:0]        ch_irq_en_i,
  input  logic [NUM_CH-1:0]        ch_irq_clr_i,
  output logic [NUM_CH-1:0]        ch_busy_o,
  output logic [NUM_CH*2-1:0]      ch_stat_o,
  output logic [NUM_CH-1:0]        ch_irq_status_o,
  output logic                     irq_o,
  output logic                     rd_cmd_valid_o,
  input  logic                     rd_cmd_ready_i,
  output logic [ADDR_W-1:0]        rd_cmd_addr_o,
  output logic [LEN_W-1:0]         rd_cmd_len_o,
  output logic [ID_W-1:0]          rd_cmd_id_o,
  input  logic                     rd_stat_valid_i,
  output logic                     rd_stat_ready_o,
  input  logic [1:0]               rd_stat_code_i,
  output logic                     wr_cmd_valid_o,
  input  logic                     wr_cmd_ready_i,
  output logic [ADDR_W-1:0]        wr_cmd_addr_o,
  output logic [LEN_W-1:0]         wr_cmd_len_o,
  output logic [ID_W-1:0]          wr_cmd_id_o,
  input  logic                     wr_stat_valid_i,
  output logic                     wr_stat_ready_o,
  input  logic [1:0]               wr_stat_code_i
);
  typedef enum logic [1:0] {ST_IDLE, ST_POST, ST_STAT} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     gnt_q, gnt_d;
  logic                rd_vld_q, rd_vld_d, wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                rd_cap_q, rd_cap_d, wr_cap_q, wr_cap_d;
  logic [1:0]          rd_code_q, rd_code_d, wr_code_q, wr_code_d;

  logic [NUM_CH-1:0]   pend_vec, grant_vec, done_vec;
  logic [1:0]          eng_code, rd_c, wr_c;
  logic                gnt_found;
  logic [ID_W-1:0]     gnt_idx, cand;

  // Per-channel state instances
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dma_ch_state u_ch (
      .clk_i        (aclk_i),
      .rst_i        (areset_i),
      .go_i         (ch_go_i[i]),
      .abort_i      (ch_abort_i[i]),
      .len_zero_i   (ch_length_i[i*LEN_W +: LEN_W] == '0),
      .grant_i      (grant_vec[i]),
      .done_i       (done_vec[i]),
      .code_i       (eng_code),
      .irq_clr_i    (ch_irq_clr_i[i]),
      .pending_o    (pend_vec[i]),
      .busy_o       (ch_busy_o[i]),
      .stat_o       (ch_stat_o[i*2 +: 2]),
      .irq_status_o (ch_irq_status_o[i])
    );
  end

  // Round-robin pick: first pending channel after the last one served
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = ID_W'((int'(rr_q) + k) % NUM_CH);
      if (!gnt_found && pend_vec[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Merged engine code; a code arriving in the final status cycle is used directly
  always_comb begin
    rd_c     = rd_cap_q ? rd_code_q : rd_stat_code_i;
    wr_c     = wr_cap_q ? wr_code_q : wr_stat_code_i;
    eng_code = (rd_c != 2'b00) ? rd_c : wr_c;
  end

  // FSM next-state, command posting and status capture
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    rd_vld_d  = rd_vld_q;
    wr_vld_d  = wr_vld_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    len_d     = len_q;
    rd_cap_d  = rd_cap_q;
    wr_cap_d  = wr_cap_q;
    rd_code_d = rd_code_q;
    wr_code_d = wr_code_q;
    grant_vec = '0;
    done_vec  = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          // Descriptor is sampled here only
          gnt_d              = gnt_idx;
          rd_addr_d          = ch_src_addr_i[gnt_idx*ADDR_W +: ADDR_W];
          wr_addr_d          = ch_dst_addr_i[gnt_idx*ADDR_W +: ADDR_W];
          len_d              = ch_length_i[gnt_idx*LEN_W +: LEN_W];
          rd_vld_d           = 1'b1;
          wr_vld_d           = 1'b1;
          rd_cap_d           = 1'b0;
          wr_cap_d           = 1'b0;
          grant_vec[gnt_idx] = 1'b1;
          state_d            = ST_POST;
        end
      end
      ST_POST: begin
        if (rd_vld_q && rd_cmd_ready_i) rd_vld_d = 1'b0;
        if (wr_vld_q && wr_cmd_ready_i) wr_vld_d = 1'b0;
        if (!rd_vld_d && !wr_vld_d) state_d = ST_STAT;
      end
      ST_STAT: begin
        if (rd_stat_valid_i && !rd_cap_q) begin
          rd_cap_d  = 1'b1;
          rd_code_d = rd_stat_code_i;
        end
        if (wr_stat_valid_i && !wr_cap_q) begin
          wr_cap_d  = 1'b1;
          wr_code_d = wr_stat_code_i;
        end
        if (rd_cap_d && wr_cap_d) begin
          done_vec[gnt_q] = 1'b1;
          rr_d            = gnt_q;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      gnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      wr_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      len_q     <= '0;
      rd_cap_q  <= 1'b0;
      wr_cap_q  <= 1'b0;
      rd_code_q <= 2'b00;
      wr_code_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      rd_vld_q  <= rd_vld_d;
      wr_vld_q  <= wr_vld_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      len_q     <= len_d;
      rd_cap_q  <= rd_cap_d;
      wr_cap_q  <= wr_cap_d;
      rd_code_q <= rd_code_d;
      wr_code_q <= wr_code_d;
    end
  end

  assign rd_cmd_valid_o  = rd_vld_q;
  assign rd_cmd_addr_o   = rd_addr_q;
  assign rd_cmd_len_o    = len_q;
  assign rd_cmd_id_o     = gnt_q;
  assign wr_cmd_valid_o  = wr_vld_q;
  assign wr_cmd_addr_o   = wr_addr_q;
  assign wr_cmd_len_o    = len_q;
  assign wr_cmd_id_o     = gnt_q;
  assign rd_stat_ready_o = (state_q == ST_STAT) && !rd_cap_q;
  assign wr_stat_ready_o = (state_q == ST_STAT) && !wr_cap_q;
  assign irq_o           = |(ch_irq_status_o & ch_irq_en_i);
endmodule
